fmc_ctrl_param: RTL and testbench

Parametrised frequency-multiplier controller for the DLL, targeting f_clk = f_ref * N / M.
- Single-clock design on the multiplied output clock `clk`; the external reference `ref_in` is synchronised and edge-detected.
- Divides the reference by M and the output by N.
- Measures clk cycles per M-reference window and issues up/dn corrections.
- Steers a saturating delay-tap select `sel` and reports lock.
- Replaces the fixed 2-bit-M / 4-bit-N controller; M, N, tap count and lock criteria are configurable.

---
 rtl/fmc_pkg.sv | 28 ++
 rtl/fmc_ctrl_param_if.sv | 29 ++
 rtl/fmc_divider.sv | 45 ++++
 rtl/fmc_ctrl_param.sv | 159 +++++++++++++++
 tb/tb_fmc_ctrl_param.sv | 311 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fmc_pkg.sv
// Shared types and helpers for the frequency-multiplier controller.
package fmc_pkg;

  // Outcome of comparing one measured window against the target ratio N.
  typedef enum logic [1:0] {
    EV_IN,
    EV_SLOW,
    EV_FAST
  } ev_e;

  // Signed tolerance compare; n - tol may go negative for small N.
  function automatic ev_e tol_cmp(input int v, input int n, input int tol);
    ev_e r;
    r = EV_IN;
    if (v < n - tol) begin
      r = EV_SLOW;
    end else if (v > n + tol) begin
      r = EV_FAST;
    end
    return r;
  endfunction

  // Increment that sticks at max_v.
  function automatic int unsigned sat_inc(input int unsigned v, input int unsigned max_v);
    return (v >= max_v) ? max_v : v + 32'd1;
  endfunction

endpackage

// File: rtl/fmc_ctrl_param_if.sv
// Reference/config inputs and control/status outputs of fmc_ctrl_param.
interface fmc_ctrl_param_if #(
  parameter int unsigned M_W    = 4,
  parameter int unsigned N_W    = 6,
  parameter int unsigned SEL_W  = 3,
  parameter int unsigned MEAS_W = N_W + 2
);
  logic              ref_in;
  logic              cfg_load;
  logic [M_W-1:0]    m_cfg;
  logic [N_W-1:0]    n_cfg;
  logic              div_m;
  logic              div_n;
  logic              up;
  logic              dn;
  logic [SEL_W-1:0]  sel;
  logic              locked;
  logic [MEAS_W-1:0] meas;

  modport master (
    output ref_in, cfg_load, m_cfg, n_cfg,
    input  div_m, div_n, up, dn, sel, locked, meas
  );

  modport slave (
    input  ref_in, cfg_load, m_cfg, n_cfg,
    output div_m, div_n, up, dn, sel, locked, meas
  );
endinterface

// File: rtl/fmc_divider.sv
// Modulo-ratio counter with enable/clear; emits a registered pulse either
// one cycle after the wrapping event or aligned with the last count value.
module fmc_divider #(
  parameter int unsigned W       = 4,
  parameter bit          PREDICT = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] ratio,
  input  logic [W-1:0] ratio_nxt,
  output logic         pulse_q
);

  logic [W-1:0] cnt_q, cnt_d;
  logic         wrap_c;
  logic         pulse_d;

  // Next count and pulse; PREDICT flags the cycle whose count will be ratio-1.
  always_comb begin
    wrap_c  = en && (cnt_q == W'(ratio - W'(1)));
    cnt_d   = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (wrap_c) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + W'(1);
    end
    pulse_d = PREDICT ? (cnt_d == W'(ratio_nxt - W'(1))) : (wrap_c && !clr);
  end

  // Counter and pulse registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end

endmodule

// File: rtl/fmc_ctrl_param.sv
// DLL frequency-multiplier controller: measures clk cycles per M reference
// periods against N and steers a saturating delay-tap select.
module fmc_ctrl_param
  import fmc_pkg::*;
#(
  parameter int unsigned M_W      = 4,
  parameter int unsigned N_W      = 6,
  parameter int unsigned SEL_W    = 3,
  parameter int unsigned SEL_RST  = 4,
  parameter int unsigned LOCK_TOL = 1,
  parameter int unsigned LOCK_CNT = 4,
  parameter int unsigned MEAS_W   = N_W + 2
) (
  input logic              clk,
  input logic              rst_n,
  fmc_ctrl_param_if.slave  bus
);

  localparam int unsigned LC_W     = $clog2(LOCK_CNT + 1);
  localparam int unsigned SEL_MAX  = (32'd1 << SEL_W) - 32'd1;
  localparam int unsigned MEAS_MAX = (32'd1 << MEAS_W) - 32'd1;

  logic              s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
  logic [M_W-1:0]    m_q, m_d;
  logic [N_W-1:0]    n_q, n_d;
  logic [MEAS_W-1:0] meas_cnt_q, meas_cnt_d;
  logic [MEAS_W-1:0] meas_q, meas_d;
  logic [MEAS_W-1:0] meas_v;
  logic              primed_q, primed_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [LC_W-1:0]   lock_cnt_q, lock_cnt_d;
  logic              locked_q, locked_d;
  logic              up_q, up_d, dn_q, dn_d;
  logic              div_m_q, div_n_q;
  logic              ref_rise, m_en;
  ev_e               ev;

  assign ref_rise = s2_q & ~s3_q;
  assign m_en     = ref_rise & ~bus.cfg_load;

  // Reference divider: counts synchronised reference rising edges.
  fmc_divider #(.W(M_W), .PREDICT(1'b0)) u_div_m (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (m_en),
    .clr       (bus.cfg_load),
    .ratio     (m_q),
    .ratio_nxt (m_d),
    .pulse_q   (div_m_q)
  );

  // Output divider: free-running, pulse aligned with count N-1.
  fmc_divider #(.W(N_W), .PREDICT(1'b1)) u_div_n (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (1'b1),
    .clr       (bus.cfg_load),
    .ratio     (n_q),
    .ratio_nxt (n_d),
    .pulse_q   (div_n_q)
  );

  // Synchroniser, config shadow, window measurement and tap steering.
  always_comb begin
    s1_d       = bus.ref_in;
    s2_d       = s1_q;
    s3_d       = s2_q;
    m_d        = m_q;
    n_d        = n_q;
    meas_v     = MEAS_W'(sat_inc(32'(meas_cnt_q), MEAS_MAX));
    meas_cnt_d = meas_v;
    meas_d     = meas_q;
    primed_d   = primed_q;
    sel_d      = sel_q;
    lock_cnt_d = lock_cnt_q;
    locked_d   = locked_q;
    up_d       = 1'b0;
    dn_d       = 1'b0;
    ev         = tol_cmp(int'(meas_v), int'(n_q), int'(LOCK_TOL));

    if (bus.cfg_load) begin
      m_d        = (bus.m_cfg == '0) ? M_W'(1) : bus.m_cfg;
      n_d        = (bus.n_cfg == '0) ? N_W'(1) : bus.n_cfg;
      meas_cnt_d = '0;
      primed_d   = 1'b0;
      sel_d      = SEL_W'(SEL_RST);
      lock_cnt_d = '0;
      locked_d   = 1'b0;
    end else if (div_m_q) begin
      meas_cnt_d = '0;
      if (!primed_q) begin
        // First window after reset/config starts mid-period; drop it.
        primed_d = 1'b1;
      end else begin
        meas_d = meas_v;
        case (ev)
          EV_SLOW: begin
            up_d       = 1'b1;
            lock_cnt_d = '0;
            locked_d   = 1'b0;
            if (sel_q != '0) sel_d = sel_q - SEL_W'(1);
          end
          EV_FAST: begin
            dn_d       = 1'b1;
            lock_cnt_d = '0;
            locked_d   = 1'b0;
            if (sel_q != SEL_W'(SEL_MAX)) sel_d = sel_q + SEL_W'(1);
          end
          default: begin
            lock_cnt_d = LC_W'(sat_inc(32'(lock_cnt_q), LOCK_CNT));
            if (lock_cnt_d == LC_W'(LOCK_CNT)) locked_d = 1'b1;
          end
        endcase
      end
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      s3_q       <= 1'b0;
      m_q        <= M_W'(1);
      n_q        <= N_W'(1);
      meas_cnt_q <= '0;
      meas_q     <= '0;
      primed_q   <= 1'b0;
      sel_q      <= SEL_W'(SEL_RST);
      lock_cnt_q <= '0;
      locked_q   <= 1'b0;
      up_q       <= 1'b0;
      dn_q       <= 1'b0;
    end else begin
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      s3_q       <= s3_d;
      m_q        <= m_d;
      n_q        <= n_d;
      meas_cnt_q <= meas_cnt_d;
      meas_q     <= meas_d;
      primed_q   <= primed_d;
      sel_q      <= sel_d;
      lock_cnt_q <= lock_cnt_d;
      locked_q   <= locked_d;
      up_q       <= up_d;
      dn_q       <= dn_d;
    end
  end

  assign bus.div_m  = div_m_q;
  assign bus.div_n  = div_n_q;
  assign bus.up     = up_q;
  assign bus.dn     = dn_q;
  assign bus.sel    = sel_q;
  assign bus.locked = locked_q;
  assign bus.meas   = meas_q;

endmodule

// File: tb/tb_fmc_ctrl_param.sv
// Bench for fmc_ctrl_param: event-level reference model checked every cycle,
// plus directed scenarios with hand-derived expectations.
module tb_fmc_ctrl_param;

  localparam int M_W      = 4;
  localparam int N_W      = 6;
  localparam int SEL_W    = 3;
  localparam int SEL_RST  = 4;
  localparam int LOCK_TOL = 1;
  localparam int LOCK_CNT = 4;
  localparam int MEAS_W   = 8;
  localparam int MEAS_MAX = 255;
  localparam int SEL_MAX  = 7;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  fmc_ctrl_param_if #(.M_W(M_W), .N_W(N_W), .SEL_W(SEL_W), .MEAS_W(MEAS_W)) bus ();

  fmc_ctrl_param #(
    .M_W(M_W), .N_W(N_W), .SEL_W(SEL_W), .SEL_RST(SEL_RST),
    .LOCK_TOL(LOCK_TOL), .LOCK_CNT(LOCK_CNT), .MEAS_W(MEAS_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  // Model state: ref sample history, event counts and timestamps.
  bit samp [3];
  int rises, mm, nn, nphase, cyc, win_start, good, msel, mmeas;
  bit primed, mlocked;
  bit x_div_m, x_div_n, x_up, x_dn;

  task automatic cmp(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Advance the model by one clk edge using the inputs the DUT sees.
  task automatic model_step();
    int  v;
    bit  rise, was_dm;
    if (!rst_n) begin
      for (int k = 0; k < 3; k++) samp[k] = 1'b0;
      rises = 0; mm = 1; nn = 1; nphase = 0; win_start = cyc;
      primed = 1'b0; msel = SEL_RST; good = 0; mlocked = 1'b0; mmeas = 0;
      x_div_m = 1'b0; x_div_n = 1'b0; x_up = 1'b0; x_dn = 1'b0;
    end else begin
      rise   = samp[1] && !samp[2];
      was_dm = x_div_m;
      x_up   = 1'b0;
      x_dn   = 1'b0;
      if (bus.cfg_load) begin
        mm = (bus.m_cfg == 0) ? 1 : int'(bus.m_cfg);
        nn = (bus.n_cfg == 0) ? 1 : int'(bus.n_cfg);
        rises = 0; nphase = 0; x_div_m = 1'b0; x_div_n = (nn == 1);
        primed = 1'b0; msel = SEL_RST; good = 0; mlocked = 1'b0; win_start = cyc;
      end else begin
        x_div_m = 1'b0;
        if (rise) begin
          rises++;
          x_div_m = (rises % mm == 0);
        end
        nphase  = (nphase + 1) % nn;
        x_div_n = (nphase == nn - 1);
        if (was_dm) begin
          v = cyc - win_start;
          if (v > MEAS_MAX) v = MEAS_MAX;
          win_start = cyc;
          if (!primed) begin
            primed = 1'b1;
          end else begin
            mmeas = v;
            if (v < nn - LOCK_TOL) begin
              x_up = 1'b1; good = 0; mlocked = 1'b0;
              if (msel > 0) msel--;
            end else if (v > nn + LOCK_TOL) begin
              x_dn = 1'b1; good = 0; mlocked = 1'b0;
              if (msel < SEL_MAX) msel++;
            end else begin
              if (good < LOCK_CNT) good++;
              if (good == LOCK_CNT) mlocked = 1'b1;
            end
          end
        end
      end
      samp[2] = samp[1];
      samp[1] = samp[0];
      samp[0] = bus.ref_in;
    end
    cyc++;
  endtask

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        cmp("div_m",  int'(bus.div_m),  int'(x_div_m));
        cmp("div_n",  int'(bus.div_n),  int'(x_div_n));
        cmp("up",     int'(bus.up),     int'(x_up));
        cmp("dn",     int'(bus.dn),     int'(x_dn));
        cmp("sel",    int'(bus.sel),    msel);
        cmp("locked", int'(bus.locked), int'(mlocked));
        cmp("meas",   int'(bus.meas),   mmeas);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench timeout");
  end

  int period = 4;
  int ph = 0;

  task automatic tick();
    @(negedge clk);
    ph = (ph + 1) % period;
    bus.ref_in = (ph < (period + 1) / 2);
  endtask

  task automatic set_period(input int p);
    period = p;
    ph = ph % p;
  endtask

  // One-cycle config strobe; inputs are then scrambled to prove they are ignored.
  task automatic cfg(input int m, input int n);
    bus.cfg_load = 1'b1;
    bus.m_cfg = M_W'(m);
    bus.n_cfg = N_W'(n);
    tick();
    bus.cfg_load = 1'b0;
    bus.m_cfg = M_W'(5);
    bus.n_cfg = N_W'(3);
  endtask

  task automatic run_until_locked(input int budget, output int ndm, output int nud, output bit ok);
    ndm = 0; nud = 0; ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (bus.div_m) ndm++;
      if (bus.up || bus.dn) nud++;
      if (bus.locked) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    int ndm, nud, nu, nd, nz;
    bit ok, prev;
    bus.ref_in = 1'b0;
    bus.cfg_load = 1'b0;
    bus.m_cfg = '0;
    bus.n_cfg = '0;
    rst_n = 1'b0;
    @(posedge clk);
    chk_en = 1'b1;
    tick();
    tick();
    cmp("rst_sel",    int'(bus.sel), SEL_RST);
    cmp("rst_locked", int'(bus.locked), 0);
    cmp("rst_meas",   int'(bus.meas), 0);
    cmp("rst_div_n",  int'(bus.div_n), 0);
    rst_n = 1'b1;

    // In-tolerance: 4-clk reference, M=2 gives 8 cycles per window.
    set_period(4);
    cfg(2, 8);
    run_until_locked(200, ndm, nud, ok);
    cmp("A_lock_seen",      int'(ok), 1);
    cmp("A_div_m_at_lock",  ndm, 5);
    cmp("A_updn_pulses",    nud, 0);
    cmp("A_meas",           int'(bus.meas), 8);
    cmp("A_sel",            int'(bus.sel), 4);

    // Too fast: 10 cycles per window; first dn drops lock immediately.
    set_period(5);
    ok = 1'b0;
    prev = 1'b0;
    for (int i = 0; i < 100; i++) begin
      prev = bus.locked;
      tick();
      if (bus.dn) begin
        ok = 1'b1;
        break;
      end
    end
    cmp("C_dn_seen",       int'(ok), 1);
    cmp("C_locked_before", int'(prev), 1);
    cmp("C_locked_at_dn",  int'(bus.locked), 0);
    repeat (60) tick();
    cmp("C_sel_sat",       int'(bus.sel), 7);
    cmp("C_meas",          int'(bus.meas), 10);

    // cfg_load landing on a div_m cycle suppresses that evaluation.
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (x_div_m) begin
        ok = 1'b1;
        break;
      end
    end
    cmp("E_div_m_found", int'(ok), 1);
    cfg(2, 8);
    cmp("E_no_dn",     int'(bus.dn), 0);
    cmp("E_no_up",     int'(bus.up), 0);
    cmp("E_meas_hold", int'(bus.meas), 10);
    cmp("E_sel_rst",   int'(bus.sel), 4);
    cmp("E_locked",    int'(bus.locked), 0);
    ndm = 0;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (bus.div_m) ndm++;
      if (bus.dn) begin
        ok = 1'b1;
        break;
      end
    end
    cmp("E_dn_seen",          int'(ok), 1);
    cmp("E_div_m_before_dn",  ndm, 2);

    // Too slow: 6 cycles per window; sel walks down to 0 and holds.
    set_period(3);
    cfg(2, 8);
    nu = 0;
    nd = 0;
    repeat (80) begin
      tick();
      nu += int'(bus.up);
      nd += int'(bus.dn);
    end
    cmp("B_sel_floor", int'(bus.sel), 0);
    cmp("B_meas",      int'(bus.meas), 6);
    cmp("B_locked",    int'(bus.locked), 0);
    cmp("B_dn_pulses", nd, 0);
    cmp("B_up_ge5",    int'(nu >= 5), 1);

    // Reset mid-window while locked, then relock from scratch.
    set_period(4);
    cfg(2, 8);
    run_until_locked(200, ndm, nud, ok);
    cmp("F_lock_seen", int'(ok), 1);
    for (int i = 0; i < 20; i++) begin
      if (!x_div_m) break;
      tick();
    end
    tick();
    rst_n = 1'b0;
    tick();
    cmp("F_rst_div_m",  int'(bus.div_m), 0);
    cmp("F_rst_div_n",  int'(bus.div_n), 0);
    cmp("F_rst_up",     int'(bus.up), 0);
    cmp("F_rst_dn",     int'(bus.dn), 0);
    cmp("F_rst_locked", int'(bus.locked), 0);
    cmp("F_rst_meas",   int'(bus.meas), 0);
    cmp("F_rst_sel",    int'(bus.sel), 4);
    rst_n = 1'b1;
    cfg(2, 8);
    run_until_locked(200, ndm, nud, ok);
    cmp("F_relock_seen",  int'(ok), 1);
    cmp("F_relock_div_m", ndm, 5);

    // Zero ratios behave as M=N=1; 2-clk reference gives 2 cycles per window.
    set_period(2);
    cfg(0, 0);
    nz = 0;
    ndm = 0;
    nud = 0;
    repeat (30) begin
      tick();
      if (!bus.div_n) nz++;
      if (bus.div_m) ndm++;
      if (bus.up || bus.dn) nud++;
    end
    cmp("D_div_n_low_cycles", nz, 0);
    cmp("D_div_m_ge13",       int'(ndm >= 13), 1);
    cmp("D_meas",             int'(bus.meas), 2);
    cmp("D_locked",           int'(bus.locked), 1);
    cmp("D_updn_pulses",      nud, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
